// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: synchronised 16x oversampling with 3-sample majority vote,
// one-entry valid/ready holding register, and framing/overrun/break pulses.
module uart_rx_oversampled #(
    parameter int CLOCK_FREQ  = 25000000,
    parameter int BIT_RATE    = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun_error,
    output logic       break_detect,
    output logic       busy
);

    localparam int DIV_RAW = CLOCK_FREQ / (BIT_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    generate
        if (OVERSAMPLE != 16) begin : g_bad_oversample
            $error("uart_rx_oversampled: OVERSAMPLE must be 16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_oversampled: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rx_s, rx_s_d;
    logic [DIV_W-1:0]   div_q;
    logic [3:0]         tick_cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               samp7_q, samp8_q;
    logic               tick, at9, at15, maj, start_edge;
    logic               load_req, ferr_req;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = (state_q == IDLE) && rx_s_d && !rx_s;
    assign tick       = (div_q == DIV_LAST);
    assign at9        = tick && (tick_cnt_q == 4'd9);
    assign at15       = tick && (tick_cnt_q == 4'd15);
    assign maj        = (samp7_q & samp8_q) | (samp7_q & rx_s) | (samp8_q & rx_s);

    // Both counters restart on the start edge to phase-align to the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            tick_cnt_q <= '0;
        end else if (start_edge) begin
            div_q      <= '0;
            tick_cnt_q <= '0;
        end else if (tick) begin
            div_q      <= '0;
            tick_cnt_q <= tick_cnt_q + 4'd1;
        end else begin
            div_q      <= div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        ferr_req = 1'b0;
        case (state_q)
            IDLE:      if (start_edge) state_d = START;
            START: begin
                if (at9 && maj)  state_d = IDLE;
                else if (at15)   state_d = DATA;
            end
            DATA:      if (at15 && bit_idx_q == 3'd7) state_d = STOP;
            STOP: begin
                // Leaving mid-stop-bit lets the next start edge be caught early.
                if (at9) begin
                    if (maj) begin
                        load_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp7_q   <= 1'b1;
            samp8_q   <= 1'b1;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            if (tick && tick_cnt_q == 4'd7) samp7_q <= rx_s;
            if (tick && tick_cnt_q == 4'd8) samp8_q <= rx_s;
            if (state_q == START && at15)   bit_idx_q <= 3'd0;
            if (state_q == DATA) begin
                if (at9)  shift_q[bit_idx_q] <= maj;
                if (at15) bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

    // A load coinciding with a handshake replaces the byte without overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= ferr_req;
            break_detect  <= ferr_req && (shift_q == 8'h00);
            if (load_req) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
